// File: rtl/cmd_rcv_auth_if.sv
// rtl/cmd_rcv_auth_if.sv - received-byte handshake between the BLE command receiver and its consumer
interface cmd_rcv_auth_if;
    logic [7:0] rx_data;
    logic       rdy;
    logic       clr_rdy;

    modport master (output rx_data, output rdy, input clr_rdy);
    modport slave  (input rx_data, input rdy, output clr_rdy);
endinterface

// File: rtl/cmd_rcv_auth.sv
// rtl/cmd_rcv_auth.sv - BLE 8N1 command receiver with G/S power authorisation FSM
// Define FRAME_CHK_EN to reject frames with a bad stop bit and report them on frm_err.
module cmd_rcv_auth #(
    parameter int         BAUD_DIV = 2604,
    parameter logic [7:0] CMD_GO   = 8'h47,
    parameter logic [7:0] CMD_STOP = 8'h53
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           RX,
    input  logic           rider_off,
    cmd_rcv_auth_if.master bus,
    output logic           pwr_up,
    output logic           frm_err
);
    localparam int            CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);

    typedef enum logic       {IDLE, RECV}      rx_state_t;
    typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

    logic          r_rx_meta;
    logic          r_rx_s;
    logic          r_rx_prev;
    rx_state_t     r_rx_state;
    logic [CW-1:0] r_baud_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_data;
    logic          r_rdy;
    auth_state_t   r_auth_state;
    logic          r_pwr_up;

    logic          w_fall;
    logic          w_start;
    logic          w_stop_sample;
    logic          w_byte_done;

    assign w_fall        = r_rx_prev & ~r_rx_s;
    assign w_stop_sample = (r_rx_state == RECV) && (r_baud_cnt == '0) && (r_bit_cnt == 4'd9);

`ifdef FRAME_CHK_EN
    logic r_frm_err;
    logic r_wait_hi;

    // After a bad stop bit the line may still be held low (break); stay disarmed until it idles.
    assign w_start     = w_fall & ~r_wait_hi;
    assign w_byte_done = w_stop_sample & r_rx_s;
    assign frm_err     = r_frm_err;
`else
    assign w_start     = w_fall;
    assign w_byte_done = w_stop_sample;
    assign frm_err     = 1'b0;
`endif

    assign bus.rx_data = r_rx_data;
    assign bus.rdy     = r_rdy;
    assign pwr_up      = r_pwr_up;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_rdy      <= 1'b0;
`ifdef FRAME_CHK_EN
            r_frm_err  <= 1'b0;
            r_wait_hi  <= 1'b0;
`endif
        end else begin
`ifdef FRAME_CHK_EN
            r_frm_err <= 1'b0;
`endif
            // Later assignments in this block override the acknowledge, so a completing byte wins.
            if (bus.clr_rdy) begin
                r_rdy <= 1'b0;
            end
            case (r_rx_state)
                IDLE: begin
`ifdef FRAME_CHK_EN
                    if (r_wait_hi && r_rx_s) begin
                        r_wait_hi <= 1'b0;
                    end
`endif
                    if (w_start) begin
                        r_baud_cnt <= HALF_BIT;
                        r_bit_cnt  <= 4'd0;
                        r_rx_state <= RECV;
                    end
                end
                RECV: begin
                    if (r_baud_cnt != '0) begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end else begin
                        r_baud_cnt <= FULL_BIT;
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd0) begin
                            if (r_rx_s) begin
                                r_rx_state <= IDLE;
                            end else begin
                                r_rdy <= 1'b0;
                            end
                        end else if (r_bit_cnt != 4'd9) begin
                            r_shift <= {r_rx_s, r_shift[7:1]};
                        end else begin
                            r_rx_state <= IDLE;
                            if (w_byte_done) begin
                                r_rx_data <= r_shift;
                                r_rdy     <= 1'b1;
                            end
`ifdef FRAME_CHK_EN
                            else begin
                                r_frm_err <= 1'b1;
                                r_wait_hi <= 1'b1;
                            end
`endif
                        end
                    end
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

    // Commands act on byte_done directly, so an unacknowledged byte still drives authorisation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_auth_state <= OFF;
            r_pwr_up     <= 1'b0;
        end else begin
            r_pwr_up <= (r_auth_state != OFF);
            case (r_auth_state)
                OFF: begin
                    if (w_byte_done && r_shift == CMD_GO) begin
                        r_auth_state <= PWR1;
                    end
                end
                PWR1: begin
                    if (w_byte_done && r_shift == CMD_STOP) begin
                        r_auth_state <= rider_off ? OFF : PWR2;
                    end
                end
                PWR2: begin
                    if (rider_off) begin
                        r_auth_state <= OFF;
                    end else if (w_byte_done && r_shift == CMD_GO) begin
                        r_auth_state <= PWR1;
                    end
                end
                default: r_auth_state <= OFF;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_rcv_auth.sv
// tb/tb_cmd_rcv_auth.sv - self-checking bench for cmd_rcv_auth (BAUD_DIV scaled to 16)
module tb_cmd_rcv_auth;
    localparam int B = 16;

    logic clk = 1'b0;
    logic rst;
    logic RX;
    logic rider_off;
    logic pwr_up;
    logic frm_err;

    cmd_rcv_auth_if bus();

    cmd_rcv_auth #(.BAUD_DIV(B), .CMD_GO(8'h47), .CMD_STOP(8'h53)) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .rider_off (rider_off),
        .bus       (bus),
        .pwr_up    (pwr_up),
        .frm_err   (frm_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Rising-edge monitor on rdy and frm_err, sampled on the falling clock edge.
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    logic [7:0] rise_data_prev = 8'h00;
    logic       pwr_at_rise = 1'b0;
    logic       pwr_after = 1'b0;
    logic       capture_next = 1'b0;
    logic       rdy_q = 1'b0;
    logic       frm_q = 1'b0;
    int         frm_pulses = 0;
    int         frm_hi = 0;

    always @(negedge clk) begin
        if (capture_next) begin
            pwr_after    = pwr_up;
            capture_next = 1'b0;
        end
        if (bus.rdy === 1'b1 && rdy_q !== 1'b1) begin
            rise_cnt++;
            rise_cyc       = cyc;
            rise_data_prev = rise_data;
            rise_data      = bus.rx_data;
            pwr_at_rise    = pwr_up;
            capture_next   = 1'b1;
        end
        if (frm_err === 1'b1) frm_hi++;
        if (frm_err === 1'b1 && frm_q !== 1'b1) frm_pulses++;
        rdy_q = bus.rdy;
        frm_q = frm_err;
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int clr_at, output int t0);
        t0 = 0;
        for (int n = 0; n < 10 * B; n++) begin
            @(negedge clk);
            if (n == 0) t0 = cyc;
            if (n < B) RX = 1'b0;
            else if (n < 9 * B) RX = d[(n - B) / B];
            else RX = stop_v;
            bus.clr_rdy = (n == clr_at);
        end
        bus.clr_rdy = 1'b0;
    endtask

    task automatic idle(input int k);
        RX = 1'b1;
        repeat (k) @(negedge clk);
    endtask

    task automatic clr_pulse;
        @(negedge clk);
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; RX = 1'b1; rider_off = 1'b0; bus.clr_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
        n_checks++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", bus.rdy); end
        n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL reset_pwr_up: got %b expected 0", pwr_up); end
        n_checks++; if (frm_err !== 1'b0) begin n_fail++; $display("FAIL reset_frm_err: got %b expected 0", frm_err); end
        // Reset in the middle of a frame must discard the partial byte.
        for (int n = 0; n < 3 * B; n++) begin
            @(negedge clk);
            RX = (n < B) ? 1'b0 : n[4];
        end
        @(negedge clk); rst = 1'b1; RX = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2 * B);
        n_checks++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL midreset_rdy: got %b expected 0", bus.rdy); end
        begin
            int t0;
            send_frame(8'h5A, 1'b1, -1, t0);
        end
        idle(4);
        n_checks++; if (bus.rx_data !== 8'h5A) begin n_fail++; $display("FAIL midreset_rx_data: got %h expected 5a", bus.rx_data); end
        n_checks++; if (bus.rdy !== 1'b1) begin n_fail++; $display("FAIL midreset_rdy_after: got %b expected 1", bus.rdy); end
        clr_pulse();
    endtask

    task automatic test_go;
        int t0;
        int lat;
        send_frame(8'h47, 1'b1, -1, t0);
        idle(4);
        lat = rise_cyc - t0;
        n_checks++; if (lat < 154 || lat > 157) begin n_fail++; $display("FAIL go_latency: got %0d expected 154..157", lat); end
        n_checks++; if (bus.rx_data !== 8'h47) begin n_fail++; $display("FAIL go_rx_data: got %h expected 47", bus.rx_data); end
        n_checks++; if (bus.rdy !== 1'b1) begin n_fail++; $display("FAIL go_rdy: got %b expected 1", bus.rdy); end
        n_checks++; if (pwr_at_rise !== 1'b0) begin n_fail++; $display("FAIL go_pwr_at_done: got %b expected 0", pwr_at_rise); end
        n_checks++; if (pwr_after !== 1'b1) begin n_fail++; $display("FAIL go_pwr_after_done: got %b expected 1", pwr_after); end
        clr_pulse();
        n_checks++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL go_clr_rdy: got %b expected 0", bus.rdy); end
    endtask

    task automatic test_stop_rider_on;
        int t0;
        rider_off = 1'b0;
        send_frame(8'h53, 1'b1, -1, t0);
        idle(4);
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL pwr2_pwr_up: got %b expected 1", pwr_up); end
        idle(300);
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL pwr2_hold: got %b expected 1", pwr_up); end
        rider_off = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL pwr2_rider_off: got %b expected 0", pwr_up); end
        rider_off = 1'b0;
        clr_pulse();
    endtask

    task automatic test_stop_rider_off;
        int t0;
        send_frame(8'h47, 1'b1, -1, t0);
        idle(4);
        rider_off = 1'b1;
        send_frame(8'h53, 1'b1, -1, t0);
        idle(4);
        n_checks++; if (pwr_at_rise !== 1'b1) begin n_fail++; $display("FAIL stop_pwr_at_done: got %b expected 1", pwr_at_rise); end
        n_checks++; if (pwr_after !== 1'b0) begin n_fail++; $display("FAIL stop_pwr_after_done: got %b expected 0", pwr_after); end
        send_frame(8'h41, 1'b1, -1, t0);
        idle(4);
        n_checks++; if (bus.rx_data !== 8'h41 || bus.rdy !== 1'b1) begin n_fail++; $display("FAIL other_byte_rx: got %h/%b expected 41/1", bus.rx_data, bus.rdy); end
        n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL other_byte_pwr: got %b expected 0", pwr_up); end
        rider_off = 1'b0;
        clr_pulse();
    endtask

    task automatic test_glitch;
        int base;
        int t0;
        base = rise_cnt;
        @(negedge clk); RX = 1'b0;
        repeat (B / 2 - 1) @(negedge clk);
        idle(3 * B);
        n_checks++; if (rise_cnt !== base) begin n_fail++; $display("FAIL glitch_no_byte: got %0d bytes expected %0d", rise_cnt, base); end
        n_checks++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL glitch_rdy: got %b expected 0", bus.rdy); end
        send_frame(8'h47, 1'b1, -1, t0);
        idle(4);
        n_checks++; if (rise_cnt !== base + 1) begin n_fail++; $display("FAIL glitch_next_count: got %0d expected %0d", rise_cnt, base + 1); end
        n_checks++; if (bus.rx_data !== 8'h47) begin n_fail++; $display("FAIL glitch_next_data: got %h expected 47", bus.rx_data); end
        clr_pulse();
    endtask

    task automatic test_back_to_back;
        int base;
        int t0;
        base = rise_cnt;
        send_frame(8'hA5, 1'b1, -1, t0);
        // clr_rdy lands on the stop-sample cycle of the second byte.
        send_frame(8'h3C, 1'b1, 9 * B + B / 2 + 3, t0);
        @(negedge clk);
        n_checks++; if (bus.rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_set_wins: got %b expected 1", bus.rdy); end
        n_checks++; if (bus.rx_data !== 8'h3C) begin n_fail++; $display("FAIL b2b_rx_data: got %h expected 3c", bus.rx_data); end
        n_checks++; if (rise_cnt !== base + 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", rise_cnt, base + 2); end
        n_checks++; if (rise_data_prev !== 8'hA5) begin n_fail++; $display("FAIL b2b_first: got %h expected a5", rise_data_prev); end
        clr_pulse();
        n_checks++; if (bus.rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_clr: got %b expected 0", bus.rdy); end
    endtask

    task automatic test_frame_err;
        int base_rise;
        int base_pulses;
        int base_hi;
        int t0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL ferr_reset_pwr: got %b expected 0", pwr_up); end
        base_rise = rise_cnt; base_pulses = frm_pulses; base_hi = frm_hi;
        send_frame(8'h47, 1'b0, -1, t0);
        idle(2 * B);
`ifdef FRAME_CHK_EN
        n_checks++; if (frm_pulses !== base_pulses + 1 || frm_hi !== base_hi + 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d pulses/%0d cycles expected 1/1", frm_pulses - base_pulses, frm_hi - base_hi); end
        n_checks++; if (bus.rdy !== 1'b0 || rise_cnt !== base_rise) begin n_fail++; $display("FAIL ferr_rdy: got %b expected 0", bus.rdy); end
        n_checks++; if (pwr_up !== 1'b0) begin n_fail++; $display("FAIL ferr_pwr: got %b expected 0", pwr_up); end
`else
        n_checks++; if (frm_pulses !== base_pulses || frm_hi !== base_hi) begin n_fail++; $display("FAIL ferr_tied: got %0d pulses expected 0", frm_pulses - base_pulses); end
        n_checks++; if (bus.rdy !== 1'b1 || bus.rx_data !== 8'h47 || rise_cnt !== base_rise + 1) begin n_fail++; $display("FAIL ferr_accept: got %b/%h expected 1/47", bus.rdy, bus.rx_data); end
        n_checks++; if (pwr_up !== 1'b1) begin n_fail++; $display("FAIL ferr_pwr: got %b expected 1", pwr_up); end
`endif
        clr_pulse();
    endtask

    initial begin
        test_reset();
        test_go();
        test_stop_rider_on();
        test_stop_rider_off();
        test_glitch();
        test_back_to_back();
        test_frame_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
